// File: rtl/ex_flag_branch_stage_pkg.sv
// ============================================================================
// Module : wisc_pkg
// Brief  : Shared opcodes, condition codes, flag indices and stage FSM type
//          for the WISC-S15 EX flag/branch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wisc_pkg;

   localparam logic [2:0] ADD  = 3'b000;
   localparam logic [2:0] SUB  = 3'b001;
   localparam logic [2:0] NAND = 3'b010;
   localparam logic [2:0] XOR  = 3'b011;
   localparam logic [2:0] INC  = 3'b100;
   localparam logic [2:0] SRA  = 3'b101;
   localparam logic [2:0] SRL  = 3'b110;
   localparam logic [2:0] SLL  = 3'b111;

   localparam logic [2:0] COND_NEQ    = 3'b000;
   localparam logic [2:0] COND_EQ     = 3'b001;
   localparam logic [2:0] COND_GT     = 3'b010;
   localparam logic [2:0] COND_LT     = 3'b011;
   localparam logic [2:0] COND_GTE    = 3'b100;
   localparam logic [2:0] COND_LTE    = 3'b101;
   localparam logic [2:0] COND_OVFL   = 3'b110;
   localparam logic [2:0] COND_UNCOND = 3'b111;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   // Bits of {Z,V,N} that an opcode is allowed to overwrite.
   function automatic logic [2:0] flag_write_mask(input logic [2:0] op);
      logic [2:0] mask;
      mask = 3'b000;
      case (op)
         ADD, SUB, INC: mask = 3'b111;
         NAND, XOR:     mask = 3'b100;
         default:       mask = 3'b000;
      endcase
      return mask;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ex_flag_branch_stage_if.sv
// ============================================================================
// Module : ex_flag_branch_stage_if
// Brief  : Upstream (ALU side) and downstream (MEM/WB side) handshake bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ex_flag_branch_stage_if #(
   parameter int DATA_W = 16
) ();

   logic              in_valid;
   logic              in_ready;
   logic              alu_done;
   logic [2:0]        alu_op;
   logic [DATA_W-1:0] alu_result;
   logic [2:0]        alu_flags;
   logic              is_branch;
   logic [2:0]        cond;
   logic [DATA_W-1:0] branch_target;
   logic [3:0]        wb_reg;
   logic              wb_en;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [3:0]        out_wb_reg;
   logic              out_wb_en;

   modport master (
      output in_valid, alu_done, alu_op, alu_result, alu_flags, is_branch,
             cond, branch_target, wb_reg, wb_en, out_ready,
      input  in_ready, out_valid, out_result, out_wb_reg, out_wb_en
   );

   modport slave (
      input  in_valid, alu_done, alu_op, alu_result, alu_flags, is_branch,
             cond, branch_target, wb_reg, wb_en, out_ready,
      output in_ready, out_valid, out_result, out_wb_reg, out_wb_en
   );

endinterface

`default_nettype wire

// File: rtl/ex_flag_branch_stage_branch_cond_eval.sv
// ============================================================================
// Module : branch_cond_eval
// Brief  : Combinational branch condition check against committed {Z,V,N}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_cond_eval
   import wisc_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [2:0] flags,
   output logic       taken
);

   logic w_z;
   logic w_v;
   logic w_n;

   assign w_z = flags[FLAG_Z];
   assign w_v = flags[FLAG_V];
   assign w_n = flags[FLAG_N];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_NEQ:    taken = !w_z;
         COND_EQ:     taken = w_z;
         COND_GT:     taken = !w_z && !w_n;
         COND_LT:     taken = w_n;
         COND_GTE:    taken = w_z || !w_n;
         COND_LTE:    taken = w_z || w_n;
         COND_OVFL:   taken = w_v;
         COND_UNCOND: taken = 1'b1;
         default:     taken = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ex_flag_branch_stage.sv
// ============================================================================
// Module : ex_flag_branch_stage
// Brief  : EX output register, flag register and branch resolve/squash FSM.
//          Optional branch statistics counters under EX_BRANCH_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_flag_branch_stage
   import wisc_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int DATA_W       = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   ex_flag_branch_stage_if.slave   bus,
   output logic [2:0]              flags_q,
   output logic                    branch_taken,
   output logic [DATA_W-1:0]       branch_pc,
   output logic                    flush_upstream
`ifdef EX_BRANCH_STATS_EN
   ,
   output logic [15:0]             br_taken_cnt,
   output logic [15:0]             br_nt_cnt
`endif
);

   localparam logic [2:0] c_flush_init = 3'(FLUSH_CYCLES);

   state_t            r_state;
   logic [2:0]        r_cnt;
   logic [2:0]        r_flags;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_result;
   logic [3:0]        r_out_wb_reg;
   logic              r_out_wb_en;
   logic              r_branch_taken;
   logic [DATA_W-1:0] r_branch_pc;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_run_accept;
   logic              w_cond_taken;
   logic              w_take;
   logic [2:0]        w_flag_mask;

   assign w_in_ready   = !r_out_valid || bus.out_ready;
   assign w_accept     = bus.in_valid && bus.alu_done && w_in_ready;
   assign w_run_accept = w_accept && (r_state == RUN);
   assign w_take       = w_run_accept && bus.is_branch && w_cond_taken;
   assign w_flag_mask  = flag_write_mask(bus.alu_op);

   // Branches see the flags committed before this edge, never the current op's.
   branch_cond_eval u_branch_cond_eval (
      .cond  (bus.cond),
      .flags (r_flags),
      .taken (w_cond_taken)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= RUN;
         r_cnt          <= 3'd0;
         r_flags        <= 3'b000;
         r_out_valid    <= 1'b0;
         r_out_result   <= '0;
         r_out_wb_reg   <= 4'd0;
         r_out_wb_en    <= 1'b0;
         r_branch_taken <= 1'b0;
         r_branch_pc    <= '0;
      end else begin
         r_branch_taken <= 1'b0;

         if (w_run_accept) begin
            r_out_valid  <= 1'b1;
            r_out_result <= bus.alu_result;
            r_out_wb_reg <= bus.wb_reg;
            r_out_wb_en  <= bus.wb_en && !bus.is_branch;
         end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
         end

         if (w_run_accept && !bus.is_branch) begin
            r_flags <= (r_flags & ~w_flag_mask) | (bus.alu_flags & w_flag_mask);
         end

         if (r_state == RUN) begin
            if (w_take) begin
               r_state        <= FLUSH;
               r_cnt          <= c_flush_init;
               r_branch_taken <= 1'b1;
               r_branch_pc    <= bus.branch_target;
            end
         end else begin
            // Wrong-path slots are consumed (handshaken) but never forwarded.
            if (r_cnt == 3'd0) begin
               r_state <= RUN;
            end else if (w_accept) begin
               r_cnt <= r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  r_state <= RUN;
               end
            end
         end
      end
   end

`ifdef EX_BRANCH_STATS_EN
   logic [15:0] r_br_taken_cnt;
   logic [15:0] r_br_nt_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_br_taken_cnt <= 16'd0;
         r_br_nt_cnt    <= 16'd0;
      end else if (w_run_accept && bus.is_branch) begin
         if (w_cond_taken) begin
            if (r_br_taken_cnt != 16'hFFFF) r_br_taken_cnt <= r_br_taken_cnt + 16'd1;
         end else begin
            if (r_br_nt_cnt != 16'hFFFF) r_br_nt_cnt <= r_br_nt_cnt + 16'd1;
         end
      end
   end

   assign br_taken_cnt = r_br_taken_cnt;
   assign br_nt_cnt    = r_br_nt_cnt;
`endif

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_result = r_out_result;
   assign bus.out_wb_reg = r_out_wb_reg;
   assign bus.out_wb_en  = r_out_wb_en;
   assign flags_q        = r_flags;
   assign branch_taken   = r_branch_taken;
   assign branch_pc      = r_branch_pc;
   assign flush_upstream = (r_state == FLUSH);

endmodule

`default_nettype wire

// File: tb/tb_ex_flag_branch_stage.sv
// ============================================================================
// Module : tb_ex_flag_branch_stage
// Brief  : Self-checking bench: reference model + output scoreboard plus
//          directed scenario checks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_flag_branch_stage;
   import wisc_pkg::*;

   localparam int FLUSH_N = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  flags_q;
   logic        branch_taken;
   logic [15:0] branch_pc;
   logic        flush_upstream;
`ifdef EX_BRANCH_STATS_EN
   logic [15:0] br_taken_cnt;
   logic [15:0] br_nt_cnt;
`endif

   ex_flag_branch_stage_if #(.DATA_W(16)) bus ();

   ex_flag_branch_stage #(.FLUSH_CYCLES(FLUSH_N), .DATA_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .flags_q        (flags_q),
      .branch_taken   (branch_taken),
      .branch_pc      (branch_pc),
      .flush_upstream (flush_upstream)
`ifdef EX_BRANCH_STATS_EN
      ,
      .br_taken_cnt   (br_taken_cnt),
      .br_nt_cnt      (br_nt_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  rg;
      logic        en;
      logic        br;
   } sb_t;

   sb_t         sb_q[$];
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic        m_ov;
   logic [2:0]  m_flags;
   logic        m_flush;
   int          m_cnt;
   logic        m_bt;
   logic [15:0] m_bpc;

   function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
      logic z, v, n;
      z = f[2]; v = f[1]; n = f[0];
      case (c)
         3'b000:  return !z;
         3'b001:  return z;
         3'b010:  return !z && !n;
         3'b011:  return n;
         3'b100:  return z || !n;
         3'b101:  return z || n;
         3'b110:  return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic drive(input logic [2:0] op, input logic [15:0] res, input logic [2:0] fl,
                        input logic br, input logic [2:0] c, input logic [15:0] tgt,
                        input logic [3:0] rg, input logic en);
      bus.in_valid      = 1'b1;
      bus.alu_done      = 1'b1;
      bus.alu_op        = op;
      bus.alu_result    = res;
      bus.alu_flags     = fl;
      bus.is_branch     = br;
      bus.cond          = c;
      bus.branch_target = tgt;
      bus.wb_reg        = rg;
      bus.wb_en         = en;
   endtask

   // One clock: check DUT against the model, drain the scoreboard, advance the model.
   task automatic tick();
      logic rdy, acc;
      sb_t  e, got;
      @(negedge clk);
      if (!rst) begin
         total_cnt++; if (flags_q !== m_flags) $display("FAIL mdl_flags: got %b expected %b", flags_q, m_flags); else pass_cnt++;
         total_cnt++; if (bus.out_valid !== m_ov) $display("FAIL mdl_out_valid: got %b expected %b", bus.out_valid, m_ov); else pass_cnt++;
         total_cnt++; if (flush_upstream !== m_flush) $display("FAIL mdl_flush: got %b expected %b", flush_upstream, m_flush); else pass_cnt++;
         total_cnt++; if (branch_taken !== m_bt) $display("FAIL mdl_branch_taken: got %b expected %b", branch_taken, m_bt); else pass_cnt++;
         total_cnt++; if (bus.in_ready !== (!m_ov || bus.out_ready)) $display("FAIL mdl_in_ready: got %b expected %b", bus.in_ready, !m_ov || bus.out_ready); else pass_cnt++;
         if (m_bt) begin
            total_cnt++; if (branch_pc !== m_bpc) $display("FAIL mdl_branch_pc: got %h expected %h", branch_pc, m_bpc); else pass_cnt++;
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
               $display("FAIL sb_unexpected: got result %h with no expected entry", bus.out_result);
            end else begin
               e = sb_q.pop_front();
               got = '{res: bus.out_result, rg: bus.out_wb_reg, en: bus.out_wb_en, br: e.br};
               if (e.br) begin got.res = e.res; end
               if (got !== e) $display("FAIL sb_output: got res=%h reg=%h en=%b expected res=%h reg=%h en=%b",
                                       bus.out_result, bus.out_wb_reg, bus.out_wb_en, e.res, e.rg, e.en);
               else pass_cnt++;
            end
         end
      end
      rdy = !m_ov || bus.out_ready;
      acc = bus.in_valid && bus.alu_done && rdy;
      if (rst) begin
         m_ov = 1'b0; m_flags = 3'b000; m_flush = 1'b0; m_cnt = 0; m_bt = 1'b0; m_bpc = 16'h0000;
         sb_q.delete();
      end else begin
         m_bt = 1'b0;
         if (!m_flush && acc) begin
            e = '{res: bus.alu_result, rg: bus.wb_reg, en: bus.wb_en && !bus.is_branch, br: bus.is_branch};
            sb_q.push_back(e);
            m_ov = 1'b1;
            if (!bus.is_branch) begin
               case (bus.alu_op)
                  ADD, SUB, INC: m_flags = bus.alu_flags;
                  NAND, XOR:     m_flags[2] = bus.alu_flags[2];
                  default:       m_flags = m_flags;
               endcase
            end else if (cond_ok(bus.cond, m_flags)) begin
               m_flush = 1'b1; m_cnt = FLUSH_N; m_bt = 1'b1; m_bpc = bus.branch_target;
            end
         end else begin
            if (bus.out_ready) m_ov = 1'b0;
            if (m_flush) begin
               if (m_cnt == 0) m_flush = 1'b0;
               else if (acc) begin
                  m_cnt--;
                  if (m_cnt == 0) m_flush = 1'b0;
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.alu_done = 1'b0; bus.out_ready = 1'b1;
      drive(ADD, 16'h0, 3'b000, 1'b0, 3'b000, 16'h0, 4'h0, 1'b0);
      bus.in_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); else pass_cnt++;
      total_cnt++; if (flags_q !== 3'b000) $display("FAIL rst_flags: got %b expected 000", flags_q); else pass_cnt++;
      total_cnt++; if ({branch_taken, branch_pc} !== 17'h0) $display("FAIL rst_branch: got %b/%h expected 0/0000", branch_taken, branch_pc); else pass_cnt++;
      total_cnt++; if (flush_upstream !== 1'b0) $display("FAIL rst_flush: got %b expected 0", flush_upstream); else pass_cnt++;
      total_cnt++; if ({bus.out_result, bus.out_wb_reg, bus.out_wb_en} !== 21'h0) $display("FAIL rst_out_regs: got %h/%h/%b expected 0", bus.out_result, bus.out_wb_reg, bus.out_wb_en); else pass_cnt++;
   endtask

   task automatic test_taken_flush();
      drive(ADD, 16'h0000, 3'b100, 1'b0, 3'b000, 16'h0, 4'h1, 1'b1); tick();
      total_cnt++; if (flags_q !== 3'b100) $display("FAIL add_flags: got %b expected 100", flags_q); else pass_cnt++;
      drive(ADD, 16'h0000, 3'b000, 1'b1, COND_EQ, 16'h0040, 4'h0, 1'b0); tick();
      total_cnt++; if (branch_taken !== 1'b1 || branch_pc !== 16'h0040) $display("FAIL eq_taken: got %b/%h expected 1/0040", branch_taken, branch_pc); else pass_cnt++;
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_wb_en !== 1'b0) $display("FAIL branch_out: got valid=%b en=%b expected 1/0", bus.out_valid, bus.out_wb_en); else pass_cnt++;
      drive(ADD, 16'hDEAD, 3'b011, 1'b0, 3'b000, 16'h0, 4'h2, 1'b1); tick();
      total_cnt++; if (bus.out_valid !== 1'b0 || flags_q !== 3'b100) $display("FAIL drop1: got valid=%b flags=%b expected 0/100", bus.out_valid, flags_q); else pass_cnt++;
      total_cnt++; if (branch_taken !== 1'b0) $display("FAIL taken_pulse: got %b expected 0", branch_taken); else pass_cnt++;
      drive(SUB, 16'hBEEF, 3'b011, 1'b0, 3'b000, 16'h0, 4'h3, 1'b1); tick();
      total_cnt++; if (bus.out_valid !== 1'b0 || flush_upstream !== 1'b0) $display("FAIL drop2: got valid=%b flush=%b expected 0/0", bus.out_valid, flush_upstream); else pass_cnt++;
      drive(SLL, 16'h0008, 3'b000, 1'b0, 3'b000, 16'h0, 4'h4, 1'b1); tick();
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0008) $display("FAIL post_flush: got valid=%b res=%h expected 1/0008", bus.out_valid, bus.out_result); else pass_cnt++;
   endtask

   task automatic test_flag_rules();
      drive(SUB, 16'hFFFF, 3'b011, 1'b0, 3'b000, 16'h0, 4'h5, 1'b1); tick();
      total_cnt++; if (flags_q !== 3'b011) $display("FAIL sub_flags: got %b expected 011", flags_q); else pass_cnt++;
      drive(XOR, 16'h0000, 3'b100, 1'b0, 3'b000, 16'h0, 4'h6, 1'b1); tick();
      total_cnt++; if (flags_q !== 3'b111) $display("FAIL xor_flags: got %b expected 111", flags_q); else pass_cnt++;
      drive(SLL, 16'h0000, 3'b000, 1'b0, 3'b000, 16'h0, 4'h7, 1'b1); tick();
      total_cnt++; if (flags_q !== 3'b111) $display("FAIL sll_flags: got %b expected 111", flags_q); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bus.in_valid = 1'b0; tick();
      bus.out_ready = 1'b0;
      drive(INC, 16'h1234, 3'b000, 1'b0, 3'b000, 16'h0, 4'h3, 1'b1); tick();
      drive(ADD, 16'h5555, 3'b111, 1'b0, 3'b000, 16'h0, 4'h9, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++; if (bus.in_ready !== 1'b0 || bus.out_result !== 16'h1234 || flags_q !== 3'b000)
            $display("FAIL stall_hold: got ready=%b res=%h flags=%b expected 0/1234/000", bus.in_ready, bus.out_result, flags_q);
         else pass_cnt++;
      end
      bus.out_ready = 1'b1; tick();
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h5555 || flags_q !== 3'b111)
         $display("FAIL drain_reload: got valid=%b res=%h flags=%b expected 1/5555/111", bus.out_valid, bus.out_result, flags_q);
      else pass_cnt++;
   endtask

   task automatic test_alu_done();
      drive(XOR, 16'h0001, 3'b000, 1'b0, 3'b000, 16'h0, 4'hA, 1'b1);
      bus.alu_done = 1'b0; tick();
      total_cnt++; if (bus.out_valid !== 1'b0 || flags_q !== 3'b111) $display("FAIL no_done: got valid=%b flags=%b expected 0/111", bus.out_valid, flags_q); else pass_cnt++;
      bus.alu_done = 1'b1; tick();
      total_cnt++; if (bus.out_valid !== 1'b1 || flags_q !== 3'b011) $display("FAIL done_accept: got valid=%b flags=%b expected 1/011", bus.out_valid, flags_q); else pass_cnt++;
   endtask

   task automatic test_cond();
      drive(SUB, 16'h7FFF, 3'b010, 1'b0, 3'b000, 16'h0, 4'h1, 1'b1); tick();
      drive(ADD, 16'h0, 3'b000, 1'b1, COND_OVFL, 16'h0100, 4'h0, 1'b0); tick();
      total_cnt++; if (branch_taken !== 1'b1 || branch_pc !== 16'h0100) $display("FAIL ovfl_taken: got %b/%h expected 1/0100", branch_taken, branch_pc); else pass_cnt++;
      drive(SLL, 16'h0, 3'b000, 1'b0, 3'b000, 16'h0, 4'h2, 1'b1); tick(); tick();
      drive(ADD, 16'h0, 3'b000, 1'b1, COND_EQ, 16'h0200, 4'h0, 1'b0); tick();
      total_cnt++; if (branch_taken !== 1'b0 || flush_upstream !== 1'b0 || bus.out_valid !== 1'b1)
         $display("FAIL eq_not_taken: got taken=%b flush=%b valid=%b expected 0/0/1", branch_taken, flush_upstream, bus.out_valid);
      else pass_cnt++;
      drive(ADD, 16'h0, 3'b000, 1'b1, COND_UNCOND, 16'h0300, 4'h0, 1'b0); tick();
      total_cnt++; if (branch_taken !== 1'b1 || branch_pc !== 16'h0300 || flush_upstream !== 1'b1)
         $display("FAIL uncond_taken: got %b/%h flush=%b expected 1/0300/1", branch_taken, branch_pc, flush_upstream);
      else pass_cnt++;
      drive(SLL, 16'h0, 3'b000, 1'b0, 3'b000, 16'h0, 4'h2, 1'b1); tick(); tick();
   endtask

   task automatic test_reset_in_flush();
      drive(ADD, 16'h0, 3'b000, 1'b1, COND_UNCOND, 16'h0400, 4'h0, 1'b0); tick();
      total_cnt++; if (flush_upstream !== 1'b1) $display("FAIL flush_entry: got %b expected 1", flush_upstream); else pass_cnt++;
      rst = 1'b1;
      drive(SLL, 16'h0, 3'b000, 1'b0, 3'b000, 16'h0, 4'h2, 1'b1); tick();
      rst = 1'b0;
      total_cnt++; if (flush_upstream !== 1'b0 || flags_q !== 3'b000 || bus.out_valid !== 1'b0 || branch_taken !== 1'b0)
         $display("FAIL rst_mid_flush: got flush=%b flags=%b valid=%b taken=%b expected 0/000/0/0", flush_upstream, flags_q, bus.out_valid, branch_taken);
      else pass_cnt++;
      bus.in_valid = 1'b0; tick();
   endtask

   task automatic test_stats();
      logic [4:0] pattern;
      pattern = 5'b11010;
      for (int i = 0; i < 5; i++) begin
         drive(ADD, 16'h0, 3'b000, 1'b1, pattern[i] ? COND_UNCOND : COND_EQ, 16'h0500, 4'h0, 1'b0); tick();
         if (pattern[i]) begin
            drive(SLL, 16'h0, 3'b000, 1'b0, 3'b000, 16'h0, 4'h2, 1'b1); tick(); tick();
         end
      end
`ifdef EX_BRANCH_STATS_EN
      total_cnt++; if (br_taken_cnt !== 16'd3) $display("FAIL stats_taken: got %0d expected 3", br_taken_cnt); else pass_cnt++;
      total_cnt++; if (br_nt_cnt !== 16'd2) $display("FAIL stats_nt: got %0d expected 2", br_nt_cnt); else pass_cnt++;
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive(3'($urandom_range(0, 7)), 16'($urandom), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 16'($urandom),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.alu_done  = ($urandom_range(0, 4) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      tick(); tick(); tick();
      total_cnt++; if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size()); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_taken_flush();
      test_flag_rules();
      test_back_to_back();
      test_alu_done();
      test_cond();
      test_reset_in_flush();
      test_stats();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got no completion expected finish before 1000000");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/ex_flag_branch_stage.md
Name: ex_flag_branch_stage

Overview:
- Sits directly downstream of the ALU in the WISC-S15 16-bit datapath.
- Accepts the ALU result and the Z/V/N flags into an output pipeline register toward MEM/WB.
- Holds the architectural flag register and applies the per-opcode flag-write rules.
- Resolves conditional branches against the committed flags, and squashes wrong-path instructions after a taken branch.

Parameters:
- FLUSH_CYCLES, 2: number of accepted-slot cycles discarded after a taken branch (1..7).
- DATA_W, 16: datapath width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- alu_done  in  1  ALU result stable; acceptance requires in_valid && alu_done && in_ready.
- alu_op  in  3  ALU control: ADD=000, SUB=001, NAND=010, XOR=011, INC=100, SRA=101, SRL=110, SLL=111.
- alu_result  in  16  ALU result.
- alu_flags  in  3  {Z,V,N} from ALU.
- is_branch  in  1  instruction is a conditional branch (no flag write, no reg write).
- cond  in  3  branch condition code.
- branch_target  in  16  resolved target PC.
- wb_reg  in  4  destination register.
- wb_en  in  1  register write enable.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  downstream accepts.
- out_result  out  16  registered result.
- out_wb_reg  out  4  registered destination.
- out_wb_en  out  1  registered write enable.
- flags_q  out  3  committed {Z,V,N}.
- branch_taken  out  1  one-cycle registered pulse.
- branch_pc  out  16  target, valid while branch_taken=1.
- flush_upstream  out  1  high whenever state=FLUSH.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_result=0, out_wb_reg=0, out_wb_en=0.
  - flags_q=3'b000, branch_taken=0, branch_pc=0.
  - state=RUN, flush counter=0.
  - Reset overrides everything, including mid-FLUSH and a pending out_valid.
- in_ready = !out_valid || out_ready. This is combinational, one-entry pipeline.
- Accept = in_valid && alu_done && in_ready.
- Latency: one cycle from accept to out_valid.
- When out_ready=1 and there is no accept, out_valid clears. While out_valid=1 and out_ready=0, all out_* hold.
- Flag write, applied only on an accept in RUN with is_branch=0:
  - ADD, SUB, INC: Z, V, N all loaded from alu_flags.
  - NAND, XOR: only Z loaded; V and N retain their value.
  - SRA, SRL, SLL: no flag change.
- Branches:
  - Evaluated on accept in RUN, using flags_q before this edge. A flag op accepted on the preceding cycle is visible.
  - A branch sets out_valid=1 with out_wb_en=0.
- Condition codes:
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z && !N
  - 011 LT: N
  - 100 GTE: Z || !N
  - 101 LTE: Z || N
  - 110 OVFL: V
  - 111 UNCOND: 1
- FSM, states RUN and FLUSH:
  - RUN→FLUSH: on accept of a taken branch. Next cycle: branch_taken=1, branch_pc=branch_target, counter loaded with FLUSH_CYCLES.
  - FLUSH:
    - in_ready follows the normal rule, but accepted instructions are dropped: no out_valid, no flag write, no branch evaluation.
    - The counter decrements on each dropped accept.
    - FLUSH→RUN when the counter reaches 1 and an accept occurs, or when the counter is 0.
  - Not-taken branch: stays in RUN.
- Simultaneous out_ready drain and new accept: output reloads with the new instruction, out_valid stays 1.
- alu_done=0 with in_valid=1: no accept, no state change.

Optional Feature:
- Macro: EX_BRANCH_STATS_EN.
- Defined:
  - Adds outputs br_taken_cnt[15:0] and br_nt_cnt[15:0].
  - Each counts branches accepted in RUN (taken and not-taken respectively).
  - Counts saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Package wisc_pkg:
  - ALU opcode localparams ADD..SLL.
  - Condition-code localparams.
  - Flag index constants FLAG_Z=2, FLAG_V=1, FLAG_N=0.
  - State enum {RUN, FLUSH}.
- One sub-module, branch_cond_eval: combinational. Inputs cond[2:0] and flags[2:0]; output taken.

Test Plan:
1. Reset, then ADD alu_result=16'h0000, alu_flags=3'b100 → flags_q=3'b100 next cycle. Then branch cond=001, target=16'h0040 → branch_taken pulse with branch_pc=16'h0040, and the next 2 accepted inputs are dropped (out_valid=0).
2. SUB with alu_flags=3'b011 → flags_q=3'b011. Then XOR with alu_flags=3'b100 → flags_q=3'b111. Then SLL with alu_flags=3'b000 → flags_q=3'b111.
3. out_valid=1 with out_ready=0 for 3 cycles, in_valid=1 → in_ready=0, out_result held at its prior value (e.g. 16'h1234), flags_q unchanged.
4. flags_q=3'b010: cond=110 → taken; cond=001 → not taken, stays RUN; cond=111 → taken.
5. rst=1 while in FLUSH with counter=2 → state=RUN, flags_q=0, out_valid=0, flush_upstream=0 the next cycle.
6. With EX_BRANCH_STATS_EN: 3 taken and 2 not-taken branches → br_taken_cnt=3, br_nt_cnt=2.
